// File: rtl/ascon_prog_sequencer.sv
// ascon_prog_sequencer: runs a stored ASCON instruction program against the
// ASCON system core. It handles the push/load/init/process/tag/pull sequence
// itself, so the host only writes the program and streams blocks.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   prog_we/prog_waddr/prog_wdata program memory write ({kind[1:0], opcode[5:0]})
//   prog_len, start               program length and start pulse (IDLE only)
//   in_valid/in_data/in_ready     input block handshake
//   core_instr, core_*_blk_en     instruction and block enables to the core
//   core_block                    block driven to the core data/text inputs
//   core_ready, core_out          core status (ready) and result word
//   out_valid/out_data/out_ready  output buffer head and pop
//   busy, done, err, pc           run status, completion pulse, timeout flag, PC
module ascon_prog_sequencer #(
  parameter int unsigned WIDTH      = 128,
  parameter int unsigned PROG_DEPTH = 32,
  parameter int unsigned OUT_DEPTH  = 4,
  parameter int unsigned TIMEOUT    = 1024
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          prog_we,
  input  logic [$clog2(PROG_DEPTH)-1:0] prog_waddr,
  input  logic [7:0]                    prog_wdata,
  input  logic [$clog2(PROG_DEPTH):0]   prog_len,
  input  logic                          start,
  input  logic                          in_valid,
  input  logic [WIDTH-1:0]              in_data,
  output logic                          in_ready,
  output logic [5:0]                    core_instr,
  output logic                          core_data_blk_en,
  output logic                          core_txt_blk_en,
  output logic [WIDTH-1:0]              core_block,
  input  logic                          core_ready,
  input  logic [WIDTH-1:0]              core_out,
  output logic                          out_valid,
  output logic [WIDTH-1:0]              out_data,
  input  logic                          out_ready,
  output logic                          busy,
  output logic                          done,
  output logic                          err,
  output logic [$clog2(PROG_DEPTH):0]   pc
);
  localparam int unsigned AW = $clog2(PROG_DEPTH);
  localparam int unsigned OW = $clog2(OUT_DEPTH);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [5:0]  OP_HALT = 6'h3f;

  typedef enum logic [2:0] {
    IDLE, FETCH, WAIT_IN, ISSUE, SETTLE, WAIT_RDY, CAPTURE, HALT
  } state_t;

  state_t         r_state, w_state_nxt;
  logic [7:0]     r_prog [PROG_DEPTH];
  logic [7:0]     r_entry;
  logic [AW:0]    r_pc, w_pc_nxt;
  logic [AW:0]    r_len;
  logic           r_err;
  logic [5:0]     r_instr;
  logic [WIDTH-1:0] r_block;
  logic [TW-1:0]  r_tcnt;
  logic [WIDTH-1:0] r_obuf [OUT_DEPTH];
  logic [OW-1:0]  r_wp, r_rp;
  logic [OW:0]    r_cnt;

  logic [1:0]     w_kind;
  logic [5:0]     w_op;
  logic           w_full, w_push, w_pop, w_timeout;

  assign w_kind    = r_entry[7:6];
  assign w_op      = r_entry[5:0];
  assign w_full    = (r_cnt == (OW+1)'(OUT_DEPTH));
  assign w_push    = (r_state == CAPTURE) && !w_full;
  assign w_pop     = out_ready && (r_cnt != '0);
  assign w_timeout = (r_tcnt == TW'(TIMEOUT - 1));

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    case (r_state)
      IDLE: if (start) begin
        w_pc_nxt    = '0;
        w_state_nxt = (prog_len == '0) ? HALT : FETCH;
      end
      FETCH: begin
        if ((r_pc == r_len) || (w_op == OP_HALT)) w_state_nxt = HALT;
        else if ((w_kind == 2'd1) || (w_kind == 2'd2)) w_state_nxt = WAIT_IN;
        else w_state_nxt = ISSUE;
      end
      WAIT_IN:  if (in_valid) w_state_nxt = ISSUE;
      ISSUE:    w_state_nxt = SETTLE;
      SETTLE:   w_state_nxt = WAIT_RDY;
      WAIT_RDY: begin
        if (core_ready) begin
          if (w_kind == 2'd3) w_state_nxt = CAPTURE;
          else begin
            w_pc_nxt    = r_pc + 1'b1;
            w_state_nxt = FETCH;
          end
        end else if (w_timeout) begin
          w_state_nxt = HALT;
        end
      end
      CAPTURE: if (!w_full) begin
        w_pc_nxt    = r_pc + 1'b1;
        w_state_nxt = FETCH;
      end
      HALT:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // The read address is the next PC, so the entry for the new PC is already
  // registered when FETCH is entered and stays valid for the whole instruction
  // (the memory cannot be written while running).
  always_ff @(posedge clk) begin
    if (prog_we && !busy) r_prog[prog_waddr] <= prog_wdata;
    r_entry <= r_prog[w_pc_nxt[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (w_push) r_obuf[r_wp] <= core_out;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_pc    <= '0;
      r_len   <= '0;
      r_err   <= 1'b0;
      r_instr <= OP_HALT;
      r_block <= '0;
      r_tcnt  <= '0;
      r_wp    <= '0;
      r_rp    <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      if ((r_state == IDLE) && start) begin
        r_err <= 1'b0;
        r_len <= prog_len;
      end else if ((r_state == WAIT_RDY) && !core_ready && w_timeout) begin
        r_err <= 1'b1;
      end
      if (w_state_nxt == ISSUE)     r_instr <= w_op;
      else if (w_state_nxt == HALT) r_instr <= OP_HALT;
      if ((r_state == WAIT_IN) && in_valid) r_block <= in_data;
      // Zero outside WAIT_RDY, so the count restarts on every entry.
      if (r_state == WAIT_RDY) r_tcnt <= r_tcnt + 1'b1;
      else                     r_tcnt <= '0;
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign in_ready         = (r_state == WAIT_IN);
  assign core_instr       = r_instr;
  assign core_data_blk_en = (r_state == ISSUE) && (w_kind == 2'd1);
  assign core_txt_blk_en  = (r_state == ISSUE) && (w_kind == 2'd2);
  assign core_block       = r_block;
  assign out_valid        = (r_cnt != '0);
  assign out_data         = r_obuf[r_rp];
  assign busy             = (r_state != IDLE) && (r_state != HALT);
  assign done             = (r_state == HALT) && !r_err;
  assign err              = r_err;
  assign pc               = r_pc;
endmodule

// File: tb/tb_ascon_prog_sequencer.sv
module tb_ascon_prog_sequencer;
  localparam int unsigned W  = 128;
  localparam int unsigned PD = 32;
  localparam int unsigned OD = 4;
  localparam int unsigned TO = 16;

  logic          clk, rst, prog_we, start, in_valid, in_ready, out_ready;
  logic [4:0]    prog_waddr;
  logic [7:0]    prog_wdata;
  logic [5:0]    prog_len, pc;
  logic [W-1:0]  in_data, core_block, core_out, out_data;
  logic [5:0]    core_instr;
  logic          core_data_blk_en, core_txt_blk_en, core_ready;
  logic          out_valid, busy, done, err;

  ascon_prog_sequencer #(.WIDTH(W), .PROG_DEPTH(PD), .OUT_DEPTH(OD), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .prog_we(prog_we), .prog_waddr(prog_waddr),
    .prog_wdata(prog_wdata), .prog_len(prog_len), .start(start),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .core_instr(core_instr), .core_data_blk_en(core_data_blk_en),
    .core_txt_blk_en(core_txt_blk_en), .core_block(core_block),
    .core_ready(core_ready), .core_out(core_out), .out_valid(out_valid),
    .out_data(out_data), .out_ready(out_ready), .busy(busy), .done(done),
    .err(err), .pc(pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_chk = 0, n_pass = 0;
  int unsigned done_cnt = 0, n_out = 0;
  logic [W-1:0] in_q[$], exp_blk[$], exp_out[$];
  logic [1:0]  p_kind [PD];
  logic [5:0]  p_op   [PD];
  logic [31:0] salt = 32'h0;
  bit          hold_low = 1'b0, dly_rand = 1'b0, pop_rand = 1'b0;
  int unsigned core_dly = 3, pop_budget = 0;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Result word the core model returns for a given instruction.
  function automatic logic [W-1:0] word(input logic [5:0] op);
    return {salt, ~salt, salt ^ {26'h0, op}, 26'h0, op};
  endfunction

  // Core model: ready drops for a delay after each new instruction; the
  // result word is presented once the instruction appears.
  initial begin : core_model
    logic [5:0] prev;
    int unsigned cnt;
    prev = 6'h3f; cnt = 0; core_ready = 1'b1; core_out = '0;
    forever begin
      @(negedge clk);
      if (done) done_cnt++;
      if (core_data_blk_en || core_txt_blk_en) begin
        if (exp_blk.size() == 0) chk("blk_extra", 1'b1, 1'b0);
        else chk("core_block", core_block, exp_blk.pop_front());
      end
      if (core_instr != prev) begin
        prev = core_instr;
        if (core_instr != 6'h3f) begin
          cnt = dly_rand ? $urandom_range(0, 5) : core_dly;
          core_out = word(core_instr);
        end
      end
      core_ready = (cnt == 0) && !hold_low;
      if (cnt != 0) cnt--;
    end
  end

  initial begin : in_driver
    in_valid = 1'b0; in_data = '0;
    forever begin
      @(negedge clk);
      in_valid = (in_q.size() != 0) && ($urandom_range(0, 3) != 0);
      if (in_valid) in_data = in_q[0];
      if (in_valid && in_ready) void'(in_q.pop_front());
    end
  end

  initial begin : out_consumer
    out_ready = 1'b0;
    forever begin
      @(negedge clk);
      out_ready = (pop_budget > 0) && (!pop_rand || ($urandom_range(0, 1) == 1));
      if (out_ready && out_valid) begin
        pop_budget--;
        n_out++;
        if (exp_out.size() == 0) chk("out_extra", 1'b1, 1'b0);
        else chk("out_data", out_data, exp_out.pop_front());
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic load(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(negedge clk);
      prog_we = 1'b1; prog_waddr = 5'(i); prog_wdata = {p_kind[i], p_op[i]};
    end
    @(negedge clk);
    prog_we = 1'b0;
  endtask

  // Expected behaviour of one run: outputs for pulls in program order, one
  // input block per push, final PC at the first halt opcode or at len.
  task automatic plan(input int unsigned len, input bit gen_in, output int unsigned epc);
    logic [W-1:0] w;
    epc = len;
    for (int unsigned i = 0; i < len; i++) begin
      if (p_op[i] == 6'h3f) begin epc = i; break; end
      if (p_kind[i] == 2'd3) exp_out.push_back(word(p_op[i]));
      else if (p_kind[i] != 2'd0 && gen_in) begin
        w = {$urandom, $urandom, $urandom, $urandom};
        in_q.push_back(w);
        exp_blk.push_back(w);
      end
    end
  endtask

  task automatic start_prog(input int unsigned len);
    @(negedge clk);
    prog_len = 6'(len); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_halt(input string tag, input int unsigned maxc);
    int unsigned i = 0;
    while (!(done || err) && i < maxc) begin @(negedge clk); i++; end
    chk({tag, "_halted"}, done || err, 1'b1);
  endtask

  task automatic drain(input string tag);
    int unsigned i = 0;
    while (exp_out.size() != 0 && i < 300) begin @(negedge clk); i++; end
    chk({tag, "_drained"}, exp_out.size(), 0);
    chk({tag, "_blocks_used"}, exp_blk.size(), 0);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_instr"}, core_instr, 6'h3f);
    chk({tag, "_den"}, core_data_blk_en, 1'b0);
    chk({tag, "_ten"}, core_txt_blk_en, 1'b0);
    chk({tag, "_block"}, core_block, '0);
    chk({tag, "_in_ready"}, in_ready, 1'b0);
    chk({tag, "_out_valid"}, out_valid, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_err"}, err, 1'b0);
    chk({tag, "_pc"}, pc, 6'd0);
  endtask

  initial begin : main
    int unsigned i, epc, d0, n0;
    logic [W-1:0] a5;
    rst = 1'b1; prog_we = 1'b0; prog_waddr = '0; prog_wdata = '0;
    prog_len = '0; start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_reset("rst");

    // Decrypt-style program: 3 data, 4 text, 12 commands, 4 pulls.
    for (int unsigned k = 0; k < 23; k++) begin
      p_op[k]   = 6'(k + 1);
      p_kind[k] = (k < 3) ? 2'd1 : (k < 7) ? 2'd2 : (k < 19) ? 2'd0 : 2'd3;
    end
    salt = $urandom; dly_rand = 1'b0; core_dly = 3; pop_rand = 1'b1; pop_budget = 1000;
    load(23);
    plan(23, 1'b1, epc);
    d0 = done_cnt; n0 = n_out;
    start_prog(23);
    wait_halt("dec", 2000);
    chk("dec_pc", pc, 6'(epc));
    chk("dec_err", err, 1'b0);
    drain("dec");
    chk("dec_nout", n_out - n0, 4);
    chk("dec_done_cnt", done_cnt - d0, 1);

    // Data pushes with the input stream stalled for 10 cycles.
    p_kind[0] = 2'd1; p_op[0] = 6'h10; p_kind[1] = 2'd1; p_op[1] = 6'h11;
    dly_rand = 1'b1;
    load(2);
    start_prog(2);
    i = 0;
    while (!in_ready && i < 20) begin @(negedge clk); i++; end
    for (int unsigned k = 0; k < 10; k++) begin
      chk("stall_in_ready", in_ready, 1'b1);
      chk("stall_no_den", core_data_blk_en, 1'b0);
      @(negedge clk);
    end
    a5 = {16{8'hA5}};
    exp_blk.push_back(a5); in_q.push_back(a5);
    a5 = {$urandom, $urandom, $urandom, $urandom};
    exp_blk.push_back(a5); in_q.push_back(a5);
    a5 = {16{8'hA5}};
    i = 0;
    while (!core_data_blk_en && i < 40) begin @(negedge clk); i++; end
    chk("stall_blk_a5", core_block, a5);
    wait_halt("stall", 200);
    chk("stall_pc", pc, 6'd2);
    drain("stall");

    // Core never ready: timeout after exactly TO cycles in WAIT_RDY.
    p_kind[0] = 2'd0; p_op[0] = 6'h21;
    hold_low = 1'b1; d0 = done_cnt;
    load(1);
    start_prog(1);
    i = 0;
    while (core_instr != 6'h21 && i < 20) begin @(negedge clk); i++; end
    chk("to_issued", core_instr, 6'h21);
    repeat (17) @(negedge clk);
    chk("to_err_early", err, 1'b0);
    @(negedge clk);
    chk("to_err", err, 1'b1);
    chk("to_instr", core_instr, 6'h3f);
    chk("to_busy", busy, 1'b0);
    @(negedge clk);
    chk("to_err_sticky", err, 1'b1);
    chk("to_no_done", done_cnt - d0, 0);
    hold_low = 1'b0;

    // Six pulls into a four-entry buffer with no consumer.
    for (int unsigned k = 0; k < 6; k++) begin p_kind[k] = 2'd3; p_op[k] = 6'(8'h30 + k); end
    pop_budget = 0; pop_rand = 1'b0; salt = $urandom; d0 = done_cnt; n0 = n_out;
    repeat (2) @(negedge clk);
    load(6);
    plan(6, 1'b0, epc);
    start_prog(6);
    chk("full_err_cleared", err, 1'b0);
    i = 0;
    while (pc != 6'd4 && i < 300) begin @(negedge clk); i++; end
    repeat (20) @(negedge clk);
    chk("full_pc_held", pc, 6'd4);
    chk("full_busy", busy, 1'b1);
    chk("full_no_done", done_cnt - d0, 0);
    @(negedge clk);
    prog_we = 1'b1; prog_waddr = 5'd5; prog_wdata = 8'h3f;
    @(negedge clk);
    prog_we = 1'b0;
    pop_budget = 2;
    wait_halt("full", 300);
    chk("full_pc", pc, 6'(epc));
    pop_rand = 1'b1; pop_budget = 100;
    drain("full");
    chk("full_nout", n_out - n0, 6);

    // Reset while waiting for the core, then rerun the retained program.
    p_kind[0] = 2'd3; p_op[0] = 6'h38; p_kind[1] = 2'd0; p_op[1] = 6'h39;
    pop_budget = 0; dly_rand = 1'b0; core_dly = 1;
    repeat (2) @(negedge clk);
    load(2);
    plan(2, 1'b0, epc);
    start_prog(2);
    i = 0;
    while (!out_valid && i < 100) begin @(negedge clk); i++; end
    hold_low = 1'b1;
    i = 0;
    while (core_instr != 6'h39 && i < 100) begin @(negedge clk); i++; end
    repeat (3) @(negedge clk);
    d0 = done_cnt;
    rst = 1'b1;
    @(negedge clk);
    chk_reset("midrst");
    rst = 1'b0; hold_low = 1'b0;
    in_q.delete(); exp_blk.delete(); exp_out.delete();
    @(negedge clk);
    chk("midrst_no_done", done_cnt - d0, 0);
    pop_budget = 100; d0 = done_cnt; n0 = n_out;
    plan(2, 1'b0, epc);
    start_prog(2);
    wait_halt("rerun", 300);
    chk("rerun_pc", pc, 6'(epc));
    drain("rerun");
    chk("rerun_nout", n_out - n0, 1);
    chk("rerun_done_cnt", done_cnt - d0, 1);

    // Halt opcode at entry 2 with a longer nominal length.
    for (int unsigned k = 0; k < 10; k++) begin p_kind[k] = 2'd3; p_op[k] = 6'(8'h28 + k); end
    p_kind[0] = 2'd0; p_op[0] = 6'h3a;
    p_kind[1] = 2'd1; p_op[1] = 6'h3b;
    p_kind[2] = 2'd0; p_op[2] = 6'h3f;
    d0 = done_cnt; dly_rand = 1'b1;
    load(10);
    plan(10, 1'b1, epc);
    start_prog(10);
    wait_halt("hop", 300);
    chk("hop_done", done, 1'b1);
    chk("hop_pc", pc, 6'(epc));
    chk("hop_err", err, 1'b0);
    drain("hop");

    // Zero-length program halts straight away.
    start_prog(0);
    wait_halt("zero", 10);
    chk("zero_done", done, 1'b1);
    chk("zero_pc", pc, 6'd0);
    @(negedge clk);
    chk("zero_done_cnt", done_cnt - d0, 2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/ascon_prog_sequencer.md
Name: ascon_prog_sequencer

Overview:
Hardware instruction sequencer that executes a stored ASCON program against the ASCON system core. It performs the push, load, init, process, tag and pull cycle in hardware, so the host only writes the program and streams blocks. It sits between the host/bus side and the core's instruction, block-enable and status interface. Block width, program depth, output buffering and ready timeout are all parametrised.

Parameters:
WIDTH, 128, data/text block width in bits
PROG_DEPTH, 32, program memory entries (power of 2)
OUT_DEPTH, 4, output buffer entries (power of 2)
TIMEOUT, 1024, max cycles to wait for core ready before error

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
prog_we  in  1  program memory write strobe
prog_waddr  in  log2(PROG_DEPTH)  program write address
prog_wdata  in  8  entry {kind[1:0], opcode[5:0]}
prog_len  in  log2(PROG_DEPTH)+1  number of entries to run
start  in  1  start pulse, accepted only in IDLE
in_valid  in  1  input block valid
in_data  in  WIDTH  input block (data or text)
in_ready  out  1  input block accepted this cycle
core_instr  out  6  instruction to core
core_data_blk_en  out  1  data block write enable to core
core_txt_blk_en  out  1  text block write enable to core
core_block  out  WIDTH  block driven to core data/text inputs
core_ready  in  1  core status_reg[0] (next/ready)
core_out  in  WIDTH  core ascon_out
out_valid  out  1  output buffer not empty
out_data  out  WIDTH  head of output buffer
out_ready  in  1  consumer pop
busy  out  1  program running
done  out  1  one-cycle pulse at normal completion
err  out  1  sticky timeout flag, cleared by start or rst
pc  out  log2(PROG_DEPTH)+1  current program counter

Behaviour:
- Reset values: core_instr=6'h3f, all enables 0, core_block=0, in_ready=0, out_valid=0, busy=0, done=0, err=0, pc=0. The output buffer is emptied. The program memory is not cleared.
- Entry kinds: 0 = command only; 1 = data push (one in_data word, pulse core_data_blk_en); 2 = text push (pulse core_txt_blk_en); 3 = pull (capture core_out into the output buffer after ready).
- FSM states: IDLE, FETCH, WAIT_IN, ISSUE, SETTLE, WAIT_RDY, CAPTURE, HALT.
- IDLE: on start, clear err and pc, then go to FETCH. If prog_len==0, go to HALT immediately.
- FETCH: the memory read has 1-cycle latency, then the state decodes:
  - opcode 6'h3f or pc==prog_len goes to HALT;
  - kinds 1/2 go to WAIT_IN;
  - other kinds go to ISSUE.
- WAIT_IN: in_ready=1. On in_valid&in_ready, latch in_data into core_block and go to ISSUE.
- ISSUE: drive core_instr=opcode for exactly one cycle with the enable for the kind, then go to SETTLE. core_instr holds the opcode until the next ISSUE.
- SETTLE: one idle cycle, so a stale core_ready is never sampled. Then go to WAIT_RDY.
- WAIT_RDY: on core_ready=1:
  - kind 3 goes to CAPTURE;
  - otherwise pc increments and the state goes to FETCH.
  - A timeout counter resets on entry. If it reaches TIMEOUT, set err, drive core_instr=6'h3f, and go to HALT without done.
- CAPTURE: if the buffer is not full, write core_out, increment pc, and go to FETCH. If the buffer is full, stall here with no data loss.
- HALT: drive core_instr=6'h3f, pulse done for 1 cycle if err=0, then go to IDLE.
- Output buffer:
  - circular buffer with count width log2(OUT_DEPTH)+1;
  - read and write pointers wrap modulo OUT_DEPTH;
  - a simultaneous push and pop keeps the count unchanged;
  - a pop when empty is ignored;
  - out_data is the registered head.
- prog_we is ignored while busy=1.
- start while busy=1 is ignored.
- rst mid-program aborts immediately to the reset values, with no done pulse.
- Command-to-command latency with core_ready already high is 4 cycles: FETCH, ISSUE, SETTLE, WAIT_RDY.

Test Plan:
- Load the 19-entry decrypt program (3 data pushes, 4 text pushes, key/nonce/tag loads, init, 3 dec-data, 3 dec-text, tag calc) plus 4 pulls. Core model ready after 3 cycles. Expect exactly 4 outputs equal to the model words, one done pulse, pc=23, err=0.
- Run 2 pushes with in_valid held low for 10 cycles. Expect in_ready=1 throughout, core_data_blk_en=0 until in_valid is asserted, and block 0xA5..A5 reaching core_block on the enable cycle.
- Hold core_ready low with TIMEOUT=16. Expect err=1 exactly 16 cycles after entering WAIT_RDY, core_instr=6'h3f, no done, busy=0.
- Run 6 pulls with OUT_DEPTH=4 and out_ready=0. Expect a stall in CAPTURE at the 5th pull with pc held. Popping 2 words lets the program finish. Outputs come out in order with no loss, and pointers wrap correctly.
- Assert rst during WAIT_RDY. Expect all outputs at reset values next cycle, out_valid=0, no done. A new start then runs cleanly.
- Include entry 6'h3f at position 2 with prog_len=10. Expect HALT after 2 commands, done pulse, pc=2.
